// File: rtl/fmult_accum_pkg.sv
// fmult_accum_pkg: shared widths, operand/FSM types and FMULT constants for the G.726 predictor estimate.
package fmult_accum_pkg;
   localparam int COEF_W = 16;
   localparam int FLT_W = 11;
   localparam int EST_W = 15;
   localparam int NTERMS = 8;
   localparam int MANT_RND = 48;
   localparam int EXP_BIAS = 26;
   localparam logic [12:0] CMAG_MASK = 13'd8191;
   localparam logic [14:0] WMAG_MASK = 15'd32767;
   typedef struct packed {
      logic sign;
      logic [3:0] exp;
      logic [5:0] mant;
   } flt_t;
   typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/fmult_accum_if.sv
// fmult_accum_if: operand, control and estimate signals between the predictor update and fmult_accum.
interface fmult_accum_if;
   import fmult_accum_pkg::*;
   logic start;
   logic [COEF_W-1:0] b1, b2, b3, b4, b5, b6, a1, a2;
   logic [FLT_W-1:0] dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2;
   logic busy;
   logic done;
   logic [EST_W-1:0] sez;
   logic [EST_W-1:0] se;
   modport master (
      output start, b1, b2, b3, b4, b5, b6, a1, a2,
      output dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2,
      input busy, done, sez, se
   );
   modport slave (
      input start, b1, b2, b3, b4, b5, b6, a1, a2,
      input dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2,
      output busy, done, sez, se
   );
endinterface

// File: rtl/fmult_accum_fmult.sv
// fmult: combinational G.726 FMULT of a 16-bit two's-complement coefficient and an 11-bit float operand.
module fmult
   import fmult_accum_pkg::*;
(
   input  logic [COEF_W-1:0] coef,
   input  flt_t              flt,
   output logic [COEF_W-1:0] w
);
   logic cs;
   logic [13:0] c_shr;
   logic [12:0] cmag;
   logic [3:0] cexp;
   logic [5:0] cmant;
   logic [4:0] wexp;
   logic [7:0] wmant;
   logic [16:0] wbase;
   logic [14:0] wmag;
   assign cs = coef[COEF_W-1];
   assign c_shr = coef[COEF_W-1:2];
   // Negative coefficients take magnitude modulo 2^13, so 0x8000..0x8003 collapse to zero.
   assign cmag = cs ? 13'(14'd0 - c_shr) & CMAG_MASK : c_shr[12:0];
   always_comb begin
      cexp = '0;
      for (int i = 0; i < 13; i++) cexp = cmag[i] ? 4'(i + 1) : cexp;
   end
   assign cmant = (cmag == '0) ? 6'd32 : 6'({cmag, 6'b0} >> cexp);
   assign wexp = {1'b0, flt.exp} + {1'b0, cexp};
   assign wmant = 8'(({6'b0, flt.mant} * {6'b0, cmant} + 12'(MANT_RND)) >> 4);
   assign wbase = {2'b0, wmant, 7'b0};
   assign wmag = 15'(wexp > 5'(EXP_BIAS) ? wbase << (wexp - 5'(EXP_BIAS))
                                         : wbase >> (5'(EXP_BIAS) - wexp)) & WMAG_MASK;
   assign w = (flt.sign ^ cs) ? 16'd0 - {1'b0, wmag} : {1'b0, wmag};
endmodule

// File: rtl/fmult_accum.sv
// fmult_accum: G.726 SEZ/SE estimate; one FMULT time-multiplexed over eight cycles,
// or eight FMULTs with an adder tree when FMULT_ACCUM_PARALLEL_EN is defined.
module fmult_accum
   import fmult_accum_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic scan_in0,
   input  logic scan_en,
   output logic scan_out0,
   fmult_accum_if.slave bus
);
   logic [COEF_W-1:0] coef_d [NTERMS];
   logic [COEF_W-1:0] coef_q [NTERMS];
   flt_t flt_d [NTERMS];
   flt_t flt_q [NTERMS];
   logic accept;
   logic done;
   logic [EST_W-1:0] sez;
   logic [EST_W-1:0] se;
   logic scan_unused;
   assign scan_unused = scan_in0 ^ scan_en;
   assign scan_out0 = 1'b0;
   assign coef_d = '{bus.b1, bus.b2, bus.b3, bus.b4, bus.b5, bus.b6, bus.a1, bus.a2};
   assign flt_d = '{flt_t'(bus.dq1), flt_t'(bus.dq2), flt_t'(bus.dq3), flt_t'(bus.dq4),
                    flt_t'(bus.dq5), flt_t'(bus.dq6), flt_t'(bus.sr1), flt_t'(bus.sr2)};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NTERMS; i++) begin
            coef_q[i] <= '0;
            flt_q[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < NTERMS; i++) begin
            coef_q[i] <= coef_d[i];
            flt_q[i] <= flt_d[i];
         end
      end
   end
`ifdef FMULT_ACCUM_PARALLEL_EN
   logic [COEF_W-1:0] w [NTERMS];
   logic [COEF_W-1:0] sezi;
   logic [COEF_W-1:0] sei;
   logic vld;
   for (genvar g = 0; g < NTERMS; g++) begin : g_fmult
      fmult u_fmult (.coef(coef_q[g]), .flt(flt_q[g]), .w(w[g]));
   end
   assign sezi = (w[0] + w[1]) + (w[2] + w[3]) + (w[4] + w[5]);
   assign sei = sezi + (w[6] + w[7]);
   assign accept = bus.start;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld <= 1'b0;
         done <= 1'b0;
         sez <= '0;
         se <= '0;
      end else begin
         vld <= bus.start;
         done <= vld;
         if (vld) begin
            sez <= sezi[COEF_W-1:1];
            se <= sei[COEF_W-1:1];
         end
      end
   end
   assign bus.busy = 1'b0;
`else
   state_t state, state_nxt;
   logic [2:0] cnt;
   logic [COEF_W-1:0] acc;
   logic [COEF_W-1:0] acc_nxt;
   logic [COEF_W-1:0] w;
   fmult u_fmult (.coef(coef_q[cnt]), .flt(flt_q[cnt]), .w(w));
   assign acc_nxt = acc + w;
   assign accept = bus.start && state == S_IDLE;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      state_nxt = (state == S_IDLE) ? (bus.start ? S_RUN : S_IDLE)
                                    : ((cnt == 3'd7) ? S_IDLE : S_RUN);
   end
   // Term order follows cnt: WB1..WB6 then WA1, WA2; SEZ is tapped after the sixth.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         acc <= '0;
         done <= 1'b0;
         sez <= '0;
         se <= '0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (bus.start) begin
               cnt <= '0;
               acc <= '0;
            end
         end else begin
            acc <= acc_nxt;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd5) sez <= acc_nxt[COEF_W-1:1];
            if (cnt == 3'd7) begin
               se <= acc_nxt[COEF_W-1:1];
               done <= 1'b1;
            end
         end
      end
   end
   assign bus.busy = (state == S_RUN);
`endif
   assign bus.done = done;
   assign bus.sez = sez;
   assign bus.se = se;
endmodule

// File: tb/tb_fmult_accum.sv
// tb_fmult_accum: random and directed checks of fmult_accum against an arithmetic G.726 FMULT/ACCUM model.
module tb_fmult_accum;
   import fmult_accum_pkg::*;
`ifdef FMULT_ACCUM_PARALLEL_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 8;
`endif
   logic clk = 1'b0;
   logic reset;
   logic scan_out0;
   int total = 0;
   int bad = 0;
   int cb [6];
   int cd [6];
   int ca [2];
   int csr [2];
   fmult_accum_if bus ();
   fmult_accum dut (
      .clk(clk), .reset(reset), .scan_in0(1'b0), .scan_en(1'b0),
      .scan_out0(scan_out0), .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int fmult_ref(input int c, input int f);
      int cs, cmag, cexp, cmant, fs, fexp, fmant, wexp, wmant, wmag;
      cs = (c >> 15) & 1;
      cmag = cs ? ((16384 - (c >> 2)) & 8191) : (c >> 2);
      cexp = 0;
      while (cexp < 13 && (1 << cexp) <= cmag) cexp++;
      cmant = (cmag == 0) ? 32 : ((cmag << 6) >> cexp);
      fs = (f >> 10) & 1;
      fexp = (f >> 6) & 15;
      fmant = f & 63;
      wexp = fexp + cexp;
      wmant = (fmant * cmant + 48) >> 4;
      wmag = (wexp > 26) ? (((wmant << 7) << (wexp - 26)) & 32767) : ((wmant << 7) >> (26 - wexp));
      return (fs ^ cs) ? ((65536 - wmag) & 65535) : wmag;
   endfunction

   task automatic clear_ops();
      for (int i = 0; i < 6; i++) begin
         cb[i] = 0;
         cd[i] = 0;
      end
      for (int i = 0; i < 2; i++) begin
         ca[i] = 0;
         csr[i] = 0;
      end
   endtask

   task automatic drive_ops();
      bus.b1 = 16'(cb[0]); bus.b2 = 16'(cb[1]); bus.b3 = 16'(cb[2]);
      bus.b4 = 16'(cb[3]); bus.b5 = 16'(cb[4]); bus.b6 = 16'(cb[5]);
      bus.dq1 = 11'(cd[0]); bus.dq2 = 11'(cd[1]); bus.dq3 = 11'(cd[2]);
      bus.dq4 = 11'(cd[3]); bus.dq5 = 11'(cd[4]); bus.dq6 = 11'(cd[5]);
      bus.a1 = 16'(ca[0]); bus.a2 = 16'(ca[1]);
      bus.sr1 = 11'(csr[0]); bus.sr2 = 11'(csr[1]);
   endtask

   task automatic scramble_ops();
      bus.b1 = 16'($urandom); bus.b2 = 16'($urandom); bus.b3 = 16'($urandom);
      bus.b4 = 16'($urandom); bus.b5 = 16'($urandom); bus.b6 = 16'($urandom);
      bus.dq1 = 11'($urandom); bus.dq2 = 11'($urandom); bus.dq3 = 11'($urandom);
      bus.dq4 = 11'($urandom); bus.dq5 = 11'($urandom); bus.dq6 = 11'($urandom);
      bus.a1 = 16'($urandom); bus.a2 = 16'($urandom);
      bus.sr1 = 11'($urandom); bus.sr2 = 11'($urandom);
   endtask

   task automatic run_check(input string tag, input bit poke_busy);
      int sezi, sei, lat;
      sezi = 0;
      for (int i = 0; i < 6; i++) sezi = (sezi + fmult_ref(cb[i], cd[i])) & 65535;
      sei = (sezi + fmult_ref(ca[0], csr[0]) + fmult_ref(ca[1], csr[1])) & 65535;
      drive_ops();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (poke_busy) check({tag, "_busy"}, 32'(bus.busy), 32'(LAT > 1));
      lat = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (poke_busy && lat == 2 && bus.busy === 1'b1) begin
            scramble_ops();
            bus.start = 1'b1;
         end
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(LAT));
      check({tag, "_sez"}, 32'(bus.sez), 32'(sezi >> 1));
      check({tag, "_se"}, 32'(bus.se), 32'(sei >> 1));
      @(negedge clk);
      check({tag, "_done1"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int dn;
      reset = 1'b0;
      bus.start = 1'b0;
      clear_ops();
      drive_ops();
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_sez", 32'(bus.sez), 32'd0);
      check("rst_se", 32'(bus.se), 32'd0);
      check("scan_out", 32'(scan_out0), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      clear_ops();
      for (int i = 0; i < 6; i++) cd[i] = 'h020;
      csr[0] = 'h020; csr[1] = 'h020;
      run_check("zero", 1'b0);
      clear_ops();
      ca[0] = 'h4000; csr[0] = 'h2A0;
      run_check("a1_pos", 1'b0);
      check("a1_pos_se_abs", 32'(bus.se), 32'd536);
      clear_ops();
      ca[0] = 'hC000; csr[0] = 'h2A0;
      run_check("a1_neg", 1'b0);
      check("a1_neg_se_abs", 32'(bus.se), 32'h7DE8);
      clear_ops();
      cb[0] = 'h4000; cd[0] = 'h2A0; ca[0] = 'h4000; csr[0] = 'h2A0;
      run_check("b1a1", 1'b1);
      check("b1a1_sez_abs", 32'(bus.sez), 32'd536);
      check("b1a1_se_abs", 32'(bus.se), 32'd1072);
      clear_ops();
      ca[0] = 'h4000; csr[0] = 'h3FF;
      run_check("wexp_hi", 1'b0);
      check("wexp_hi_se_abs", 32'(bus.se), 32'd256);
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 6; i++) begin
            cb[i] = int'($urandom_range(0, 65535));
            cd[i] = int'($urandom_range(0, 2047));
         end
         for (int i = 0; i < 2; i++) begin
            ca[i] = int'($urandom_range(0, 65535));
            csr[i] = int'($urandom_range(0, 2047));
         end
         if (n % 4 == 0) begin
            ca[0] = int'($urandom_range(0, 1)) ? 'h7FFF - int'($urandom_range(0, 4095))
                                               : 'h8000 + int'($urandom_range(0, 4095));
            csr[0] = 'h3C0 | int'($urandom_range(0, 63)) | (int'($urandom_range(0, 1)) << 10);
            cb[2] = 'h4000 + int'($urandom_range(0, 16383));
            cd[2] = 'h3C0 | int'($urandom_range(0, 1087) & 'h43F);
         end
         run_check($sformatf("rnd%0d", n), n % 3 == 0);
      end
      clear_ops();
      cb[1] = 'h2345; cd[1] = 'h1F3; ca[1] = 'hE001; csr[1] = 'h4A7;
      drive_ops();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_sez", 32'(bus.sez), 32'd0);
      check("abort_se", 32'(bus.se), 32'd0);
      reset = 1'b1;
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         dn += int'(bus.done === 1'b1);
      end
      check("abort_no_done", 32'(dn), 32'd0);
      check("abort_hold_se", 32'(bus.se), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
